// File: rtl/qd_capture_ctrl_if.sv
// Captured-position stream between qd_capture_ctrl and its consumer.
// o_pos_timestamp exists only when QD_CAPTURE_TIMESTAMP_EN is defined.
interface qd_capture_ctrl_if #(
    parameter int POSITION_SIZE = 6
);
    logic                     o_pos_valid;
    logic                     i_pos_ready;
    logic [POSITION_SIZE-1:0] o_pos_data;
`ifdef QD_CAPTURE_TIMESTAMP_EN
    logic [31:0]              o_pos_timestamp;

    modport master (
        output o_pos_valid,
        output o_pos_data,
        output o_pos_timestamp,
        input  i_pos_ready
    );

    modport slave (
        input  o_pos_valid,
        input  o_pos_data,
        input  o_pos_timestamp,
        output i_pos_ready
    );
`else
    modport master (
        output o_pos_valid,
        output o_pos_data,
        input  i_pos_ready
    );

    modport slave (
        input  o_pos_valid,
        input  o_pos_data,
        output i_pos_ready
    );
`endif
endinterface

// File: rtl/qd_capture_ctrl.sv
// Quadrature decoder capture controller: run/pause/drain FSM, config shadow
// and position FIFO. Optional macro QD_CAPTURE_TIMESTAMP_EN adds timestamps.
module qd_capture_ctrl #(
    parameter int POSITION_SIZE = 6,
    parameter int DEPTH         = 4,
    parameter int DBNC_W        = 8
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_cfg_wr,
    input  logic [DBNC_W-1:0]        i_cfg_dbnc,
    input  logic [DBNC_W-1:0]        i_cfg_delta,
    input  logic [DBNC_W-1:0]        i_cfg_steps,
    input  logic [POSITION_SIZE-1:0] i_cfg_zero,
    output logic                     o_dec_enable,
    output logic [DBNC_W-1:0]        o_dec_dbnc,
    output logic [DBNC_W-1:0]        o_dec_delta,
    output logic [DBNC_W-1:0]        o_dec_steps,
    output logic [POSITION_SIZE-1:0] o_dec_zero,
    input  logic                     i_dec_trigger,
    input  logic [POSITION_SIZE-1:0] i_dec_position,
    qd_capture_ctrl_if.master        pos_if,
    output logic [1:0]               o_state,
    output logic                     o_overflow,
    output logic                     o_cfg_pending,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     pause_second;

    logic [DBNC_W-1:0]        sh_dbnc;
    logic [DBNC_W-1:0]        sh_delta;
    logic [DBNC_W-1:0]        sh_steps;
    logic [POSITION_SIZE-1:0] sh_zero;

    logic [POSITION_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              level;
    logic [AW:0]              level_nxt;

    logic                     trig_run;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     do_pop;
    logic                     do_push;
    logic                     drop;
    logic                     direct_ld;
    logic                     shadow_ld;
    logic                     apply_shadow;

    assign trig_run   = (state == S_RUN) && i_dec_trigger;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_FULL);
    assign do_pop     = !fifo_empty && pos_if.i_pos_ready;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign do_push    = trig_run && (!fifo_full || do_pop);
    assign drop       = trig_run && fifo_full && !do_pop;

    // The decoder is off (or about to be) in these cases, so new config
    // can go straight to the outputs without a pause.
    assign direct_ld = i_cfg_wr &&
                       ((state == S_IDLE) || (state == S_DRAIN) ||
                        ((state == S_RUN) && i_stop));
    assign shadow_ld = i_cfg_wr && !direct_ld &&
                       ((state == S_RUN) || (state == S_PAUSE));
    assign apply_shadow = (state == S_PAUSE) && !i_cfg_wr && !pause_second;

    assign o_state            = state;
    assign o_dec_enable       = (state == S_RUN);
    assign o_level            = level;
    assign pos_if.o_pos_valid = !fifo_empty;
    assign pos_if.o_pos_data  = mem[rd_ptr];

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + LVL_ONE;
        end else if (!do_push && do_pop) begin
            level_nxt = level - LVL_ONE;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    state_nxt = S_DRAIN;
                end else if (i_cfg_wr) begin
                    state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (!i_cfg_wr && pause_second) begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if (level_nxt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and pause phase; a config write restarts the pause.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state        <= S_IDLE;
            pause_second <= 1'b0;
        end else begin
            state        <= state_nxt;
            pause_second <= (state == S_PAUSE) && !i_cfg_wr;
        end
    end

    // Config outputs, shadow copy and pending flag.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_dec_dbnc    <= '0;
            o_dec_delta   <= '0;
            o_dec_steps   <= '0;
            o_dec_zero    <= '0;
            sh_dbnc       <= '0;
            sh_delta      <= '0;
            sh_steps      <= '0;
            sh_zero       <= '0;
            o_cfg_pending <= 1'b0;
        end else if (direct_ld) begin
            o_dec_dbnc  <= i_cfg_dbnc;
            o_dec_delta <= i_cfg_delta;
            o_dec_steps <= i_cfg_steps;
            o_dec_zero  <= i_cfg_zero;
        end else if (shadow_ld) begin
            sh_dbnc       <= i_cfg_dbnc;
            sh_delta      <= i_cfg_delta;
            sh_steps      <= i_cfg_steps;
            sh_zero       <= i_cfg_zero;
            o_cfg_pending <= 1'b1;
        end else if (apply_shadow) begin
            o_dec_dbnc    <= sh_dbnc;
            o_dec_delta   <= sh_delta;
            o_dec_steps   <= sh_steps;
            o_dec_zero    <= sh_zero;
            o_cfg_pending <= 1'b0;
        end
    end

    // Sticky drop flag, cleared only by a start from IDLE.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if ((state == S_IDLE) && i_start) begin
            o_overflow <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; storage is cleared so data reads 0 out
    // of reset.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            level <= level_nxt;
            if (do_push) begin
                mem[wr_ptr] <= i_dec_position;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

`ifdef QD_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_mem [DEPTH];

    assign pos_if.o_pos_timestamp = ts_mem[rd_ptr];

    // Free-running cycle counter stored alongside each captured position.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            ts_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (do_push) begin
                ts_mem[wr_ptr] <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qd_capture_ctrl.sv
// Bench for qd_capture_ctrl: directed vector table, reset corner cases,
// then randomized traffic against a queue-based reference model.
module tb_qd_capture_ctrl;

    localparam int PS    = 6;
    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          i_clk;
    logic          i_aresetn;
    logic          i_start;
    logic          i_stop;
    logic          i_cfg_wr;
    logic [DW-1:0] i_cfg_dbnc;
    logic [DW-1:0] i_cfg_delta;
    logic [DW-1:0] i_cfg_steps;
    logic [PS-1:0] i_cfg_zero;
    logic          o_dec_enable;
    logic [DW-1:0] o_dec_dbnc;
    logic [DW-1:0] o_dec_delta;
    logic [DW-1:0] o_dec_steps;
    logic [PS-1:0] o_dec_zero;
    logic          i_dec_trigger;
    logic [PS-1:0] i_dec_position;
    logic [1:0]    o_state;
    logic          o_overflow;
    logic          o_cfg_pending;
    logic [$clog2(DEPTH):0] o_level;

    qd_capture_ctrl_if #(.POSITION_SIZE(PS)) pos_if ();

    qd_capture_ctrl #(
        .POSITION_SIZE(PS),
        .DEPTH        (DEPTH),
        .DBNC_W       (DW)
    ) dut (
        .i_clk         (i_clk),
        .i_aresetn     (i_aresetn),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_cfg_wr      (i_cfg_wr),
        .i_cfg_dbnc    (i_cfg_dbnc),
        .i_cfg_delta   (i_cfg_delta),
        .i_cfg_steps   (i_cfg_steps),
        .i_cfg_zero    (i_cfg_zero),
        .o_dec_enable  (o_dec_enable),
        .o_dec_dbnc    (o_dec_dbnc),
        .o_dec_delta   (o_dec_delta),
        .o_dec_steps   (o_dec_steps),
        .o_dec_zero    (o_dec_zero),
        .i_dec_trigger (i_dec_trigger),
        .i_dec_position(i_dec_position),
        .pos_if        (pos_if),
        .o_state       (o_state),
        .o_overflow    (o_overflow),
        .o_cfg_pending (o_cfg_pending),
        .o_level       (o_level)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit sp, input bit tr,
                         input logic [PS-1:0] pos, input bit rdy,
                         input bit cw, input logic [DW-1:0] cd);
        i_start            = st;
        i_stop             = sp;
        i_dec_trigger      = tr;
        i_dec_position     = pos;
        pos_if.i_pos_ready = rdy;
        i_cfg_wr           = cw;
        i_cfg_dbnc         = cd;
        i_cfg_delta        = cd + 8'd1;
        i_cfg_steps        = cd + 8'd3;
        i_cfg_zero         = cd[PS-1:0];
    endtask

    typedef struct {
        bit          st, sp, tr, rdy, cw;
        logic [5:0]  pos;
        logic [7:0]  cd;
        int          e_state, e_valid, e_data, e_level;
        int          e_ovf, e_pend, e_dbnc, e_steps;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit st, bit sp, bit tr, int pos, bit rdy,
                                bit cw, int cd, int es, int ev, int ed,
                                int el, int eo, int ep, int edb, int est);
        vec_t v;
        v.st = st; v.sp = sp; v.tr = tr; v.rdy = rdy; v.cw = cw;
        v.pos = 6'(pos); v.cd = 8'(cd);
        v.e_state = es; v.e_valid = ev; v.e_data = ed; v.e_level = el;
        v.e_ovf = eo; v.e_pend = ep; v.e_dbnc = edb; v.e_steps = est;
        tbl.push_back(v);
    endfunction

    // Reference model: spec-level state kept as plain values and a queue.
    int         m_state;
    logic [5:0] m_q[$];
    bit         m_ovf, m_pend;
    int         m_left;
    logic [7:0] md_dbnc, md_delta, md_steps, sh_dbnc, sh_delta, sh_steps;
    logic [5:0] md_zero, sh_zero;

    task automatic model_reset();
        m_state = 0; m_q.delete(); m_ovf = 0; m_pend = 0; m_left = 0;
        md_dbnc = 0; md_delta = 0; md_steps = 0; md_zero = 0;
        sh_dbnc = 0; sh_delta = 0; sh_steps = 0; sh_zero = 0;
    endtask

    task automatic model_load_dec();
        md_dbnc = i_cfg_dbnc; md_delta = i_cfg_delta;
        md_steps = i_cfg_steps; md_zero = i_cfg_zero;
    endtask

    task automatic model_step();
        if (m_q.size() > 0 && pos_if.i_pos_ready) void'(m_q.pop_front());
        if (m_state == 1 && i_dec_trigger) begin
            if (m_q.size() < DEPTH) m_q.push_back(i_dec_position);
            else m_ovf = 1;
        end
        case (m_state)
            0: begin
                if (i_cfg_wr) model_load_dec();
                if (i_start) begin m_ovf = 0; m_state = 1; end
            end
            1: begin
                if (i_stop) begin
                    if (i_cfg_wr) model_load_dec();
                    m_state = 3;
                end else if (i_cfg_wr) begin
                    sh_dbnc = i_cfg_dbnc; sh_delta = i_cfg_delta;
                    sh_steps = i_cfg_steps; sh_zero = i_cfg_zero;
                    m_pend = 1; m_state = 2; m_left = 2;
                end
            end
            2: begin
                if (i_cfg_wr) begin
                    sh_dbnc = i_cfg_dbnc; sh_delta = i_cfg_delta;
                    sh_steps = i_cfg_steps; sh_zero = i_cfg_zero;
                    m_pend = 1; m_left = 2;
                end else if (m_left == 2) begin
                    md_dbnc = sh_dbnc; md_delta = sh_delta;
                    md_steps = sh_steps; md_zero = sh_zero;
                    m_pend = 0; m_left = 1;
                end else begin
                    m_state = 1;
                end
            end
            default: begin
                if (i_cfg_wr) model_load_dec();
                if (m_q.size() == 0) m_state = 0;
            end
        endcase
    endtask

    task automatic do_reset();
        i_aresetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst state", o_state, 0);
        chk("rst valid", pos_if.o_pos_valid, 0);
        chk("rst level", o_level, 0);
        chk("rst ovf", o_overflow, 0);
        chk("rst pend", o_cfg_pending, 0);
        chk("rst en", o_dec_enable, 0);
        chk("rst dbnc", o_dec_dbnc, 0);
        chk("rst steps", o_dec_steps, 0);
        chk("rst data", pos_if.o_pos_data, 0);
        @(posedge i_clk);
        #2;
        i_aresetn = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();

        //  st sp tr pos rdy cw cd | st v data lvl ovf pend dbnc steps
        add(1,0,0, 0,1,0,0, 1,0,-1,0,0,0,0,0);
        add(0,0,1, 5,1,0,0, 1,1, 5,1,0,0,0,0);
        add(0,0,1, 6,1,0,0, 1,1, 6,1,0,0,0,0);
        add(0,0,1, 7,1,0,0, 1,1, 7,1,0,0,0,0);
        add(0,0,0, 0,1,0,0, 1,0,-1,0,0,0,0,0);
        add(0,0,1, 1,0,0,0, 1,1, 1,1,0,0,0,0);
        add(0,0,1, 2,0,0,0, 1,1, 1,2,0,0,0,0);
        add(0,0,1, 3,0,0,0, 1,1, 1,3,0,0,0,0);
        add(0,0,1, 4,0,0,0, 1,1, 1,4,0,0,0,0);
        add(0,0,1, 5,0,0,0, 1,1, 1,4,1,0,0,0);
        add(0,1,0, 0,0,0,0, 3,1, 1,4,1,0,0,0);
        add(0,0,0, 0,1,0,0, 3,1, 2,3,1,0,0,0);
        add(0,0,0, 0,0,0,0, 3,1, 2,3,1,0,0,0);
        add(0,0,1, 9,1,0,0, 3,1, 3,2,1,0,0,0);
        add(1,0,0, 0,1,0,0, 3,1, 4,1,1,0,0,0);
        add(0,0,0, 0,1,0,0, 0,0,-1,0,1,0,0,0);
        add(0,0,0, 0,1,0,0, 0,0,-1,0,1,0,0,0);
        add(1,0,0, 0,1,0,0, 1,0,-1,0,0,0,0,0);
        add(0,0,0, 0,1,1,2, 2,0,-1,0,0,1,0,0);
        add(0,0,1, 3,1,0,0, 2,0,-1,0,0,0,2,5);
        add(0,0,0, 0,1,0,0, 1,0,-1,0,0,0,2,5);
        add(0,0,0, 0,1,1,3, 2,0,-1,0,0,1,2,5);
        add(0,0,0, 0,1,1,4, 2,0,-1,0,0,1,2,5);
        add(0,0,0, 0,1,0,0, 2,0,-1,0,0,0,4,7);
        add(0,0,0, 0,1,0,0, 1,0,-1,0,0,0,4,7);
        add(0,1,0, 0,1,1,7, 3,0,-1,0,0,0,7,10);
        add(0,0,0, 0,1,0,0, 0,0,-1,0,0,0,7,10);
        add(1,0,0, 0,1,0,0, 1,0,-1,0,0,0,7,10);
        add(0,0,1, 1,0,0,0, 1,1, 1,1,0,0,7,10);
        add(0,0,1, 2,0,0,0, 1,1, 1,2,0,0,7,10);
        add(0,0,1, 3,0,0,0, 1,1, 1,3,0,0,7,10);
        add(0,0,1, 4,0,0,0, 1,1, 1,4,0,0,7,10);
        add(0,0,1, 9,1,0,0, 1,1, 2,4,0,0,7,10);
        add(0,0,0, 0,1,0,0, 1,1, 3,3,0,0,7,10);
        add(0,1,0, 0,1,0,0, 3,1, 4,2,0,0,7,10);
        add(0,0,0, 0,1,0,0, 3,1, 9,1,0,0,7,10);
        add(0,0,0, 0,1,0,0, 0,0,-1,0,0,0,7,10);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].tr, tbl[i].pos,
                  tbl[i].rdy, tbl[i].cw, tbl[i].cd);
            tick();
            chk($sformatf("v%0d state", i), o_state, tbl[i].e_state);
            chk($sformatf("v%0d en", i), o_dec_enable, tbl[i].e_state == 1);
            chk($sformatf("v%0d valid", i), pos_if.o_pos_valid, tbl[i].e_valid);
            if (tbl[i].e_data >= 0)
                chk($sformatf("v%0d data", i), pos_if.o_pos_data, tbl[i].e_data);
            chk($sformatf("v%0d level", i), o_level, tbl[i].e_level);
            chk($sformatf("v%0d ovf", i), o_overflow, tbl[i].e_ovf);
            chk($sformatf("v%0d pend", i), o_cfg_pending, tbl[i].e_pend);
            chk($sformatf("v%0d dbnc", i), o_dec_dbnc, tbl[i].e_dbnc);
            chk($sformatf("v%0d steps", i), o_dec_steps, tbl[i].e_steps);
        end

        // Reset between clock edges while running with two entries held.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 11, 0, 0, 0); tick();
        drive(0, 0, 1, 12, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mid level", o_level, 2);
        chk("mid state", o_state, 1);
        #2;
        i_aresetn = 1'b0;
        #1;
        chk("async valid", pos_if.o_pos_valid, 0);
        chk("async level", o_level, 0);
        chk("async state", o_state, 0);
        chk("async en", o_dec_enable, 0);
        do_reset();

`ifdef QD_CAPTURE_TIMESTAMP_EN
        begin
            logic [31:0] t0;
            drive(1, 0, 0, 0, 0, 0, 0); tick();
            drive(0, 0, 1, 1, 0, 0, 0); tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            repeat (9) tick();
            drive(0, 0, 1, 2, 0, 0, 0); tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            t0 = pos_if.o_pos_timestamp;
            drive(0, 0, 0, 0, 1, 0, 0); tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("ts data", pos_if.o_pos_data, 2);
            chk("ts delta", pos_if.o_pos_timestamp - t0, 10);
            do_reset();
        end
`endif

        model_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, 6'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                  8'($urandom));
            model_step();
            tick();
            chk("r state", o_state, m_state);
            chk("r en", o_dec_enable, m_state == 1);
            chk("r valid", pos_if.o_pos_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("r data", pos_if.o_pos_data, m_q[0]);
            chk("r level", o_level, m_q.size());
            chk("r ovf", o_overflow, m_ovf);
            chk("r pend", o_cfg_pending, m_pend);
            chk("r dbnc", o_dec_dbnc, md_dbnc);
            chk("r delta", o_dec_delta, md_delta);
            chk("r steps", o_dec_steps, md_steps);
            chk("r zero", o_dec_zero, md_zero);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
